// File: rtl/sin_gen_pkg.sv
// Shared definitions for the sine-sweep controller: state encoding,
// frequency-word width and the default frequency-table depth.
package sin_gen_pkg;

    localparam int FREQ_W        = 8;
    localparam int DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sweep_table.sv
// DEPTH x FREQ_W frequency register file; a write and a read of the same
// address in one cycle return the incoming data (write-first).
module sweep_table
    import sin_gen_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [FREQ_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [FREQ_W-1:0] rdata
);

    logic [FREQ_W-1:0] mem [DEPTH];

    // NOTE: the table is a small flop array, so it is cleared on reset like any
    // other state; a RAM macro could not be reset this way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];

endmodule

// File: rtl/sin_sweep_ctrl.sv
// Steps a sine generator through a programmable frequency table, holding each
// entry for a latched dwell time, optionally looping until stopped.
module sin_sweep_ctrl
    import sin_gen_pkg::*;
#(
    parameter  int DEPTH   = DEPTH_DEFAULT,
    parameter  int DWELL_W = 16,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [AW:0]        num_steps,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [FREQ_W-1:0]  cfg_data,
    output logic               gen_en,
    output logic [FREQ_W-1:0]  freq_word,
    output logic               busy,
    output logic [AW-1:0]      step_idx,
    output logic               done
);

    localparam logic [AW:0]        MAX_STEPS = (AW+1)'(DEPTH);
    localparam logic [AW:0]        ONE_STEP  = (AW+1)'(1);
    localparam logic [AW-1:0]      ONE_IDX   = AW'(1);
    localparam logic [DWELL_W-1:0] ONE_DWELL = DWELL_W'(1);

    state_t              state;
    logic                loop_q;
    logic [AW:0]         steps_q;
    logic [DWELL_W-1:0]  dwell_last;
    logic [DWELL_W-1:0]  dwell_cnt;
    logic [AW-1:0]       rd_addr;
    logic [FREQ_W-1:0]   rd_data;
    logic                step_end;
    logic                last_step;

    assign step_end  = (dwell_cnt == dwell_last);
    assign last_step = ({1'b0, step_idx} == (steps_q - ONE_STEP));

    // The table is always read at the index that the next load will need.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd_addr = '0;
        if (state == RUN && !last_step) rd_addr = step_idx + ONE_IDX;
    end

    sweep_table #(.DEPTH(DEPTH)) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gen_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            freq_word  <= '0;
            step_idx   <= '0;
            dwell_cnt  <= '0;
            dwell_last <= '0;
            steps_q    <= '0;
            loop_q     <= 1'b0;
        end else if (stop) begin
            state     <= IDLE;
            gen_en    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        loop_q     <= loop;
                        steps_q    <= (num_steps > MAX_STEPS) ? MAX_STEPS : num_steps;
                        dwell_last <= (dwell == '0) ? '0 : dwell - ONE_DWELL;
                        dwell_cnt  <= '0;
                        step_idx   <= '0;
                        if (num_steps != '0) begin
                            state     <= RUN;
                            gen_en    <= 1'b1;
                            busy      <= 1'b1;
                            freq_word <= rd_data;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (step_end) begin
                        dwell_cnt <= '0;
                        if (!last_step) begin
                            step_idx  <= step_idx + ONE_IDX;
                            freq_word <= rd_data;
                        end else if (loop_q) begin
                            step_idx  <= '0;
                            freq_word <= rd_data;
                        end else begin
                            state  <= DONE;
                            gen_en <= 1'b0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + ONE_DWELL;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sin_sweep_ctrl.sv
// Self-checking bench for sin_sweep_ctrl: vector table of sweeps, randomized
// sweeps against a queue-based reference, and hand-written corner sequences.
module tb_sin_sweep_ctrl;

    localparam int DEPTH   = 8;
    localparam int DWELL_W = 16;
    localparam int AW      = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic               loop;
    logic [AW:0]        num_steps;
    logic [DWELL_W-1:0] dwell;
    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [7:0]         cfg_data;
    logic               gen_en;
    logic [7:0]         freq_word;
    logic               busy;
    logic [AW-1:0]      step_idx;
    logic               done;

    int total = 0;
    int bad   = 0;
    int shadow [DEPTH];

    typedef struct {
        int n;
        int d;
        int exp_cycles;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    sin_sweep_ctrl #(.DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .num_steps (num_steps),
        .dwell     (dwell),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .gen_en    (gen_en),
        .freq_word (freq_word),
        .busy      (busy),
        .step_idx  (step_idx),
        .done      (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_entry(input int a, input int v);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = 8'(v);
        tick;
        cfg_we   = 1'b0;
        shadow[a] = v;
    endtask

    // Reference: the expected per-cycle freq/index trace is built from the
    // shadow table, one entry repeated max(dwell,1) times per played step.
    task automatic run_sweep(input string name, input int n, input int d,
                             input int exp_cycles, input int restart_at);
        int q_freq[$];
        int q_idx[$];
        int cnt   = 0;
        int eff_n = (n > DEPTH) ? DEPTH : n;
        int eff_d = (d < 1) ? 1 : d;
        for (int s = 0; s < eff_n; s++)
            for (int r = 0; r < eff_d; r++) begin
                q_freq.push_back(shadow[s]);
                q_idx.push_back(s);
            end
        loop      = 1'b0;
        num_steps = (AW+1)'(n);
        dwell     = DWELL_W'(d);
        start     = 1'b1;
        tick;
        start = 1'b0;
        while (gen_en === 1'b1 && cnt < 5000) begin
            if (cnt < q_freq.size()) begin
                check({name, " freq"}, freq_word, q_freq[cnt]);
                check({name, " idx"}, step_idx, q_idx[cnt]);
                check({name, " busy"}, busy, 1);
                check({name, " done early"}, done, 0);
            end
            if (cnt == restart_at) begin
                start     = 1'b1;
                num_steps = (AW+1)'(1);
                dwell     = '0;
            end
            tick;
            start = 1'b0;
            cnt++;
        end
        check({name, " run length"}, cnt, exp_cycles);
        check({name, " done pulse"}, done, 1);
        check({name, " busy at done"}, busy, 0);
        tick;
        check({name, " done width"}, done, 0);
        check({name, " gen_en after"}, gen_en, 0);
    endtask

    initial begin
        int t0, t1, n, d;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        num_steps = '0; dwell = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 0;
        tick;
        tick;
        rst = 1'b0;
        check("reset gen_en", gen_en, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset freq", freq_word, 0);
        check("reset idx", step_idx, 0);

        // Vector table of sweep configurations with hand-derived run lengths.
        vecs[0] = '{n: 4,  d: 250, exp_cycles: 1000};
        vecs[1] = '{n: 0,  d: 5,   exp_cycles: 0};
        vecs[2] = '{n: 3,  d: 0,   exp_cycles: 3};
        vecs[3] = '{n: 15, d: 2,   exp_cycles: 16};
        vecs[4] = '{n: 8,  d: 1,   exp_cycles: 8};
        vecs[5] = '{n: 1,  d: 5,   exp_cycles: 5};
        write_entry(0, 15); write_entry(1, 12); write_entry(2, 8);   write_entry(3, 4);
        write_entry(4, 33); write_entry(5, 77); write_entry(6, 200); write_entry(7, 255);
        for (int v = 0; v < 6; v++)
            run_sweep($sformatf("vec%0d", v), vecs[v].n, vecs[v].d, vecs[v].exp_cycles, -1);

        // Start during RUN must be ignored.
        run_sweep("restart", 3, 4, 12, 2);

        // Randomized tables and configurations.
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < DEPTH; a++) write_entry(a, int'($urandom_range(0, 255)));
            n = int'($urandom_range(0, 15));
            d = int'($urandom_range(0, 4));
            run_sweep($sformatf("rand%0d", it), n, d,
                      ((n > DEPTH) ? DEPTH : n) * ((d < 1) ? 1 : d),
                      int'($urandom_range(0, 3)));
        end

        // Looping sweep, then stop.
        t0 = int'($urandom_range(0, 255));
        t1 = int'($urandom_range(0, 255));
        write_entry(0, t0);
        write_entry(1, t1);
        loop = 1'b1; num_steps = 4'd2; dwell = 16'd3; start = 1'b1;
        tick;
        start = 1'b0; loop = 1'b0;
        for (int i = 0; i < 14; i++) begin
            check("loop gen_en", gen_en, 1);
            check("loop freq", freq_word, ((i / 3) % 2 != 0) ? t1 : t0);
            check("loop done", done, 0);
            tick;
        end
        stop = 1'b1;
        tick;
        stop = 1'b0;
        check("stop gen_en", gen_en, 0);
        check("stop busy", busy, 0);
        check("stop done", done, 0);
        tick;
        check("stop done later", done, 0);

        // Table writes during RUN: future loads see new data, current word does not change.
        write_entry(0, 21); write_entry(1, 22); write_entry(2, 23);
        num_steps = 4'd3; dwell = 16'd2; start = 1'b1;
        tick;
        start = 1'b0;
        check("wr c0 freq", freq_word, 21);
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 8'd55;
        tick;
        check("wr c1 freq", freq_word, 21);
        cfg_addr = 3'd1; cfg_data = 8'd99;
        tick;
        check("wr first load", freq_word, 99);
        cfg_addr = 3'd1; cfg_data = 8'd111;
        tick;
        check("wr current held", freq_word, 99);
        cfg_we = 1'b0;
        tick;
        check("wr later load c4", freq_word, 55);
        tick;
        check("wr later load c5", freq_word, 55);
        tick;
        check("wr done", done, 1);
        check("wr gen_en off", gen_en, 0);
        shadow[1] = 111; shadow[2] = 55;
        tick;

        // Reset pulsed mid-step: outputs drop without a clock edge, table clears.
        num_steps = 4'd4; dwell = 16'd10; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        check("pre-reset gen_en", gen_en, 1);
        rst = 1'b1;
        #1;
        check("async rst gen_en", gen_en, 0);
        check("async rst busy", busy, 0);
        check("async rst done", done, 0);
        check("async rst freq", freq_word, 0);
        check("async rst idx", step_idx, 0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 0;
        check("post rst done", done, 0);
        run_sweep("cleared table", 8, 1, 8, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
